stochastic_queue_bank: RTL and testbench
========================================

# stochastic_queue_bank

Synthesizable hardware equivalent of the Verilog stochastic-analysis queue tasks ($q_initialize, $q_add, $q_remove, $q_full, $q_exam). It is generalised to QUEUES independent queues of DEPTH entries, each selectable as FIFO or LIFO at initialisation. It keeps per-queue wait-time statistics from a free-running timestamp. It sits between a testbench or traffic generator and the simulation-model DUT, so queue models run in emulation and FPGA prototypes.

## Interface
Parameters:
- QUEUES, 4: number of independent queues. q_id width is QID_W = $clog2(QUEUES), minimum 1.
- DEPTH, 16: entries per queue. Power of two, at least 2.
- DATA_W, 16: width of job_id and inform_id.
- TS_W, 16: timestamp and wait-time width.

Ports:
- clk  in  1  Single clock. All logic is on its rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- cmd_valid  in  1  Command valid.
- cmd_ready  out  1  Command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  Opcode: INIT=0, ADD=1, REMOVE=2, FULL=3, EXAM=4.
- cmd_qid  in  QID_W  Target queue.
- cmd_arg  in  DATA_W  Per-op argument: q_type for INIT (1=FIFO, 2=LIFO), job_id for ADD, stat code for EXAM.
- cmd_inform  in  DATA_W  inform_id for ADD.
- rsp_valid  out  1  Response valid.
- rsp_ready  in  1  Response consumed when rsp_valid && rsp_ready.
- rsp_status  out  3  Status code, listed under Operation.
- rsp_data  out  DATA_W  Per-op result: job_id for REMOVE, 1/0 for FULL, statistic for EXAM (zero-extended or truncated to DATA_W).
- rsp_inform  out  DATA_W  inform_id for REMOVE, 0 for every other op.

## Operation
- Status codes:
  - 0: OK.
  - 1: full, ADD refused.
  - 2: q_id out of range or queue not initialised.
  - 3: empty, REMOVE refused.
  - 4: unsupported q_type or stat code.
  - 6: INIT on an already-initialised queue.
  - 7: illegal opcode.
- Per-queue state: init flag, type, head, count (0..DEPTH), max_count, min_wait, max_wait.
- Each entry stores {job_id, inform_id, ts}.
- Write and read slots:
  - ADD writes slot (head+count) mod DEPTH and increments count.
  - REMOVE on a FIFO reads slot head, then head++ and count--.
  - REMOVE on a LIFO reads slot (head+count-1) mod DEPTH, then count--.
- The free-running ts counter increments every cycle and wraps mod 2^TS_W.
- Wait time on REMOVE is (ts_now - entry.ts) mod 2^TS_W. It updates min_wait and max_wait.
- max_count updates to max(max_count, count) after each ADD.
- INIT clears count, head and max_count, sets min_wait to all-ones and max_wait to 0, sets type and sets init.
- EXAM stat codes:
  - 1: current length.
  - 3: maximum length.
  - 4: shortest wait; all-ones if nothing has been removed.
  - 5: longest wait.
  - Codes 2 and 6 (means) and any other code return status 4 with rsp_data = 0.
- FULL returns status 0 with rsp_data = (count == DEPTH).
- Any non-zero status leaves queue state unchanged. rsp_data and rsp_inform are 0.
- There is no way to de-initialise a queue except rst_n.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_status=0, rsp_data=0, rsp_inform=0. ts=0, every queue uninitialised.
- Storage contents are not reset.
- Only one command is outstanding at a time: cmd_ready = !rsp_valid.
- A command accepted at edge N drives rsp_valid=1 with the result after edge N. The latency is 1 cycle.
- The state update commits at the same edge N.
- The response holds stable until rsp_ready. rsp_valid drops on the consuming edge.
- Back-to-back throughput is one command every 2 cycles when rsp_ready is tied high.
- The timestamp for ADD and for the wait computation is ts sampled at the accepting edge.
- Wait-time wrap: an entry older than 2^TS_W cycles aliases mod 2^TS_W. This is documented, not flagged.
- Boundary cases:
  - ADD at count==DEPTH returns status 1.
  - REMOVE at count==0 returns status 3.
  - Pointer wrap at DEPTH-1 → 0 is seamless.
- If rst_n asserts mid-response, rsp_valid clears immediately (asynchronously) and the pending response is lost.

## Structure
- Package stochastic_queue_bank_pkg holds:
  - op_e
  - status codes, as localparams
  - q_type constants FIFO/LIFO
  - stat codes
- Sub-module sqb_channel, one per queue: entry RAM, head/count/type/stats registers, and the slot-index arithmetic.
- The top level holds qid decode, the ts counter, the handshake and the response mux.

## Test plan
- INIT q0 type 1; ADD jobs 10, 11, 12; REMOVE ×3 → rsp_data 10, 11, 12 in that order, each status 0.
- INIT q1 type 2; ADD 10, 11, 12; REMOVE ×3 → 12, 11, 10. Then REMOVE → status 3.
- DEPTH=16 FIFO: ADD ×16 (FULL then returns data 1), 17th ADD → status 1. REMOVE ×8 and ADD ×8 to wrap → order preserved, EXAM 3 returns 16.
- ADD at ts=5, REMOVE at ts=25, ADD at ts=30, REMOVE at ts=33 → EXAM 4 = 3, EXAM 5 = 20, EXAM 1 = 0.
- Errors:
  - ADD to uninitialised q2 → status 2.
  - INIT q0 twice → status 6.
  - INIT type 3 → status 4.
  - cmd_qid = QUEUES with QUEUES=3 → status 2.
  - op 5 → status 7.
  - EXAM code 2 → status 4.
- Hold rsp_ready low for 5 cycles → response stable and cmd_ready low. Assert rst_n low mid-response → rsp_valid 0 immediately, and afterwards ADD to q0 → status 2.

Source files
------------

// File: rtl/stochastic_queue_bank_pkg.sv
// Shared opcodes, status codes, queue types and statistic selectors
// for the stochastic queue bank.
package stochastic_queue_bank_pkg;

    typedef enum logic [2:0] {
        OP_INIT   = 3'd0,
        OP_ADD    = 3'd1,
        OP_REMOVE = 3'd2,
        OP_FULL   = 3'd3,
        OP_EXAM   = 3'd4
    } op_e;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_FULL     = 3'd1;
    localparam logic [2:0] ST_NO_QUEUE = 3'd2;
    localparam logic [2:0] ST_EMPTY    = 3'd3;
    localparam logic [2:0] ST_BAD_ARG  = 3'd4;
    localparam logic [2:0] ST_REINIT   = 3'd6;
    localparam logic [2:0] ST_BAD_OP   = 3'd7;

    localparam int QT_FIFO = 1;
    localparam int QT_LIFO = 2;

    localparam int STAT_LEN      = 1;
    localparam int STAT_MAX_LEN  = 3;
    localparam int STAT_MIN_WAIT = 4;
    localparam int STAT_MAX_WAIT = 5;

endpackage

// File: rtl/sqb_channel.sv
// One queue: entry RAM, head/count/type, wait statistics and slot arithmetic.
// The result is combinational on the current state; state commits when sel is high.
module sqb_channel
    import stochastic_queue_bank_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int TS_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] arg,
    input  logic [DATA_W-1:0] inform,
    input  logic [TS_W-1:0]   ts,
    output logic [2:0]        res_status,
    output logic [DATA_W-1:0] res_data,
    output logic [DATA_W-1:0] res_inform
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * DATA_W + TS_W;

    logic [EW-1:0]   mem [DEPTH];
    logic            init_q, init_d, lifo_q, lifo_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW:0]     count_q, count_d, max_count_q, max_count_d;
    logic [TS_W-1:0] min_wait_q, min_wait_d, max_wait_q, max_wait_d;
    logic [AW-1:0]   wr_idx, rd_idx;
    logic [EW-1:0]   rd_entry;
    logic [TS_W-1:0] wait_t;
    logic            full, mem_we;

    // Count is AW+1 bits; its low bits give the write offset (mod DEPTH).
    assign wr_idx   = head_q + count_q[AW-1:0];
    assign rd_idx   = lifo_q ? (wr_idx - AW'(1)) : head_q;
    assign rd_entry = mem[rd_idx];
    assign wait_t   = ts - rd_entry[TS_W-1:0];
    assign full     = (count_q == (AW+1)'(DEPTH));

    always_comb begin
        res_status  = ST_OK;
        res_data    = '0;
        res_inform  = '0;
        init_d      = init_q;
        lifo_d      = lifo_q;
        head_d      = head_q;
        count_d     = count_q;
        max_count_d = max_count_q;
        min_wait_d  = min_wait_q;
        max_wait_d  = max_wait_q;
        mem_we      = 1'b0;
        if (op > OP_EXAM) begin
            res_status = ST_BAD_OP;
        end else if (op == OP_INIT) begin
            if (init_q) begin
                res_status = ST_REINIT;
            end else if (arg == DATA_W'(QT_FIFO) || arg == DATA_W'(QT_LIFO)) begin
                init_d      = 1'b1;
                lifo_d      = (arg == DATA_W'(QT_LIFO));
                head_d      = '0;
                count_d     = '0;
                max_count_d = '0;
                min_wait_d  = '1;
                max_wait_d  = '0;
            end else begin
                res_status = ST_BAD_ARG;
            end
        end else if (!init_q) begin
            res_status = ST_NO_QUEUE;
        end else begin
            case (op)
                OP_ADD: begin
                    if (full) begin
                        res_status = ST_FULL;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + (AW+1)'(1);
                        if (count_d > max_count_q) max_count_d = count_d;
                    end
                end
                OP_REMOVE: begin
                    if (count_q == '0) begin
                        res_status = ST_EMPTY;
                    end else begin
                        res_data   = rd_entry[EW-1 -: DATA_W];
                        res_inform = rd_entry[TS_W +: DATA_W];
                        count_d    = count_q - (AW+1)'(1);
                        if (!lifo_q) head_d = head_q + AW'(1);
                        if (wait_t < min_wait_q) min_wait_d = wait_t;
                        if (wait_t > max_wait_q) max_wait_d = wait_t;
                    end
                end
                OP_FULL: res_data = DATA_W'(full);
                OP_EXAM: begin
                    case (arg)
                        DATA_W'(STAT_LEN):      res_data = DATA_W'(count_q);
                        DATA_W'(STAT_MAX_LEN):  res_data = DATA_W'(max_count_q);
                        DATA_W'(STAT_MIN_WAIT): res_data = DATA_W'(min_wait_q);
                        DATA_W'(STAT_MAX_WAIT): res_data = DATA_W'(max_wait_q);
                        default:                res_status = ST_BAD_ARG;
                    endcase
                end
                default: res_status = ST_BAD_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            lifo_q      <= 1'b0;
            head_q      <= '0;
            count_q     <= '0;
            max_count_q <= '0;
            min_wait_q  <= '1;
            max_wait_q  <= '0;
        end else if (sel) begin
            init_q      <= init_d;
            lifo_q      <= lifo_d;
            head_q      <= head_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
            min_wait_q  <= min_wait_d;
            max_wait_q  <= max_wait_d;
        end
    end

    // Entry storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (sel && mem_we) mem[wr_idx] <= {arg, inform, ts};
    end

endmodule

// File: rtl/stochastic_queue_bank.sv
// Bank of independent FIFO/LIFO queues with wait-time statistics, driven by a
// single-outstanding command/response interface.
module stochastic_queue_bank
    import stochastic_queue_bank_pkg::*;
#(
    parameter int QUEUES = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int TS_W   = 16,
    parameter int QID_W  = (QUEUES > 1) ? $clog2(QUEUES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [QID_W-1:0]  cmd_qid,
    input  logic [DATA_W-1:0] cmd_arg,
    input  logic [DATA_W-1:0] cmd_inform,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] rsp_inform
);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_status_q, rsp_status_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d, rsp_inform_q, rsp_inform_d;
    logic [2:0]        res_status;
    logic [DATA_W-1:0] res_data, res_inform;
    logic              accept;
    logic [2:0]        ch_status [QUEUES];
    logic [DATA_W-1:0] ch_data   [QUEUES];
    logic [DATA_W-1:0] ch_inform [QUEUES];

    // Handshake: a command transfers on cmd_valid && cmd_ready, and cmd_ready is
    // low while a response is pending; a response transfers on rsp_valid && rsp_ready
    // and is held unchanged until then.
    assign cmd_ready = !rsp_valid_q;
    assign accept    = cmd_valid && !rsp_valid_q;

    for (genvar g = 0; g < QUEUES; g++) begin : g_ch
        sqb_channel #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TS_W(TS_W)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sel        (accept && (cmd_qid == QID_W'(g))),
            .op         (cmd_op),
            .arg        (cmd_arg),
            .inform     (cmd_inform),
            .ts         (ts_q),
            .res_status (ch_status[g]),
            .res_data   (ch_data[g]),
            .res_inform (ch_inform[g])
        );
    end

    always_comb begin
        res_status = ST_NO_QUEUE;
        res_data   = '0;
        res_inform = '0;
        for (int i = 0; i < QUEUES; i++) begin
            if (cmd_qid == QID_W'(i)) begin
                res_status = ch_status[i];
                res_data   = ch_data[i];
                res_inform = ch_inform[i];
            end
        end
        // An illegal opcode outranks an out-of-range queue id.
        if (cmd_op > OP_EXAM) begin
            res_status = ST_BAD_OP;
            res_data   = '0;
            res_inform = '0;
        end
    end

    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        rsp_valid_d  = rsp_valid_q;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        rsp_inform_d = rsp_inform_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = res_status;
            rsp_data_d   = res_data;
            rsp_inform_d = res_inform;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
            rsp_inform_q <= '0;
        end else begin
            ts_q         <= ts_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
            rsp_inform_q <= rsp_inform_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_inform = rsp_inform_q;

endmodule

// File: tb/tb_stochastic_queue_bank.sv
// Scoreboard bench for stochastic_queue_bank: directed scenarios plus random
// traffic, checked against a queue-based reference model.
module tb_stochastic_queue_bank;

    localparam int QUEUES = 3;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 16;
    localparam int TS_W   = 16;
    localparam int QID_W  = 2;
    localparam int W      = 3 + 2 * DATA_W;

    localparam int INIT = 0, ADD = 1, REMOVE = 2, FULLQ = 3, EXAM = 4;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [QID_W-1:0]  cmd_qid;
    logic [DATA_W-1:0] cmd_arg;
    logic [DATA_W-1:0] cmd_inform;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_inform;

    stochastic_queue_bank #(
        .QUEUES(QUEUES), .DEPTH(DEPTH), .DATA_W(DATA_W), .TS_W(TS_W), .QID_W(QID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_qid    (cmd_qid),
        .cmd_arg    (cmd_arg),
        .cmd_inform (cmd_inform),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_data   (rsp_data),
        .rsp_inform (rsp_inform)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tb_ts;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 0;
        else        tb_ts <= tb_ts + 1;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [DATA_W-1:0] job;
        logic [DATA_W-1:0] inf;
        int                ts;
    } ent_t;

    ent_t              mq [QUEUES][$];
    bit                m_init [QUEUES];
    bit                m_lifo [QUEUES];
    int                m_maxc [QUEUES];
    logic [TS_W-1:0]   m_minw [QUEUES];
    logic [TS_W-1:0]   m_maxw [QUEUES];
    logic [W-1:0]      exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int q = 0; q < QUEUES; q++) begin
            mq[q].delete();
            m_init[q] = 1'b0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_cmd(int op, int q, logic [DATA_W-1:0] arg,
                                      logic [DATA_W-1:0] inf, int ts);
        logic [2:0]        st = 3'd0;
        logic [DATA_W-1:0] d = '0;
        logic [DATA_W-1:0] i = '0;
        logic [TS_W-1:0]   w;
        ent_t              e;
        if (op > 4) st = 3'd7;
        else if (q >= QUEUES) st = 3'd2;
        else if (op == INIT) begin
            if (m_init[q]) st = 3'd6;
            else if (arg == 1 || arg == 2) begin
                m_init[q] = 1'b1;
                m_lifo[q] = (arg == 2);
                mq[q].delete();
                m_maxc[q] = 0;
                m_minw[q] = '1;
                m_maxw[q] = '0;
            end else st = 3'd4;
        end else if (!m_init[q]) st = 3'd2;
        else begin
            case (op)
                ADD: begin
                    if (mq[q].size() == DEPTH) st = 3'd1;
                    else begin
                        e.job = arg;
                        e.inf = inf;
                        e.ts  = ts;
                        mq[q].push_back(e);
                        if (mq[q].size() > m_maxc[q]) m_maxc[q] = mq[q].size();
                    end
                end
                REMOVE: begin
                    if (mq[q].size() == 0) st = 3'd3;
                    else begin
                        if (m_lifo[q]) e = mq[q].pop_back();
                        else           e = mq[q].pop_front();
                        w = TS_W'(ts - e.ts);
                        d = e.job;
                        i = e.inf;
                        if (w < m_minw[q]) m_minw[q] = w;
                        if (w > m_maxw[q]) m_maxw[q] = w;
                    end
                end
                FULLQ: d = (mq[q].size() == DEPTH) ? 16'd1 : 16'd0;
                default: begin
                    case (arg)
                        16'd1:   d = DATA_W'(mq[q].size());
                        16'd3:   d = DATA_W'(m_maxc[q]);
                        16'd4:   d = m_minw[q];
                        16'd5:   d = m_maxw[q];
                        default: st = 3'd4;
                    endcase
                end
            endcase
        end
        exp_q.push_back({st, d, i});
    endfunction

    // ---------------- driver ----------------
    // at < 0: issue as soon as possible; otherwise issue so it is accepted with ts == at.
    task automatic send(input int op, input int qid, input logic [DATA_W-1:0] arg,
                        input logic [DATA_W-1:0] inf, input int at);
        int guard = 0;
        bit ok = 1'b0;
        while (guard < 300) begin
            @(negedge clk);
            if (cmd_ready && (at < 0 || tb_ts == at)) begin
                ok = 1'b1;
                break;
            end
            if (at >= 0 && tb_ts >= at) break;
            guard++;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: op %0d qid %0d at %0d not accepted (ts %0d)", op, qid, at, tb_ts);
            return;
        end
        cmd_op     = 3'(op);
        cmd_qid    = QID_W'(qid);
        cmd_arg    = arg;
        cmd_inform = inf;
        cmd_valid  = 1'b1;
        model_cmd(op, qid, arg, inf, tb_ts);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: status %0d data %h", rsp_status, rsp_data);
            end else begin
                check("rsp", 64'({rsp_status, rsp_data, rsp_inform}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] hold;
        int guard;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_qid = '0;
        cmd_arg = '0;
        cmd_inform = '0;
        rsp_ready = 1'b0;
        model_reset();
        #1;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_status", 64'(rsp_status), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_rsp_inform", 64'(rsp_inform), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // FIFO and LIFO ordering
        send(INIT, 0, 16'd1, 16'd0, -1);
        for (int k = 0; k < 3; k++) send(ADD, 0, 16'(10 + k), 16'($urandom), -1);
        for (int k = 0; k < 3; k++) send(REMOVE, 0, 16'd0, 16'd0, -1);
        send(INIT, 1, 16'd2, 16'd0, -1);
        for (int k = 0; k < 3; k++) send(ADD, 1, 16'(10 + k), 16'($urandom), -1);
        for (int k = 0; k < 4; k++) send(REMOVE, 1, 16'd0, 16'd0, -1);

        // error codes
        send(ADD, 2, 16'd5, 16'd0, -1);
        send(INIT, 0, 16'd1, 16'd0, -1);
        send(INIT, 2, 16'd3, 16'd0, -1);
        send(ADD, 3, 16'd5, 16'd0, -1);
        send(5, 0, 16'd0, 16'd0, -1);
        send(7, 3, 16'd0, 16'd0, -1);
        send(EXAM, 0, 16'd2, 16'd0, -1);
        send(EXAM, 0, 16'd6, 16'd0, -1);

        // fill, overflow, pointer wrap on q0 (head is no longer 0 here)
        for (int k = 0; k < DEPTH; k++) send(ADD, 0, 16'($urandom), 16'($urandom), -1);
        send(FULLQ, 0, 16'd0, 16'd0, -1);
        send(ADD, 0, 16'hDEAD, 16'd0, -1);
        for (int k = 0; k < 8; k++) send(REMOVE, 0, 16'd0, 16'd0, -1);
        for (int k = 0; k < 8; k++) send(ADD, 0, 16'($urandom), 16'($urandom), -1);
        for (int k = 0; k < DEPTH; k++) send(REMOVE, 0, 16'd0, 16'd0, -1);
        send(EXAM, 0, 16'd3, 16'd0, -1);
        send(EXAM, 0, 16'd1, 16'd0, -1);
        send(FULLQ, 0, 16'd0, 16'd0, -1);
        send(REMOVE, 0, 16'd0, 16'd0, -1);

        // random traffic
        for (int n = 0; n < 200; n++) begin
            int op, qid;
            logic [DATA_W-1:0] arg;
            op  = $urandom_range(0, 9);
            op  = (op >= 5 && op <= 7) ? ((op - 5) % 3 + 1) : (op > 7 ? 4 : op);
            if ($urandom_range(0, 19) == 0) op = $urandom_range(5, 7);
            qid = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            if (op == INIT)      arg = 16'($urandom_range(0, 3));
            else if (op == EXAM) arg = 16'($urandom_range(0, 7));
            else                 arg = 16'($urandom);
            send(op, qid, arg, 16'($urandom), -1);
        end
        drain();

        // backpressure hold, then asynchronous reset mid-response
        ready_mode = 1;
        repeat (2) @(posedge clk);
        send(EXAM, 0, 16'd1, 16'd0, -1);
        guard = 0;
        while (!rsp_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        hold = {rsp_status, rsp_data, rsp_inform};
        if (exp_q.size() != 0) check("stall_rsp_model", 64'(hold), 64'(exp_q[0]));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_hold_valid", 64'(rsp_valid), 64'd1);
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
            check("stall_hold_value", 64'({rsp_status, rsp_data, rsp_inform}), 64'(hold));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("async_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        model_reset();
        ready_mode = 2;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // after reset every queue is uninitialised; then timed wait statistics
        send(ADD, 0, 16'd1, 16'd0, -1);
        send(INIT, 2, 16'd1, 16'd0, -1);
        send(ADD, 2, 16'd100, 16'd7, 40);
        send(REMOVE, 2, 16'd0, 16'd0, 60);
        send(ADD, 2, 16'd101, 16'd8, 65);
        send(REMOVE, 2, 16'd0, 16'd0, 68);
        send(EXAM, 2, 16'd4, 16'd0, -1);
        send(EXAM, 2, 16'd5, 16'd0, -1);
        send(EXAM, 2, 16'd1, 16'd0, -1);
        drain();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
